// File: rtl/t07_mem_arbiter.sv
// Two-port external bus arbiter: instruction fetch and load/store share one rwi/busy
// memory bus, one transaction at a time, with round-robin or fixed priority and a timeout.
module t07_mem_arbiter #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int FAIR_RR        = 1
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        fetch_req_i,
   input  logic [31:0] fetch_addr_i,
   output logic        fetch_ack_o,
   output logic [31:0] fetch_data_o,
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_ack_o,
   output logic [31:0] data_rdata_o,
   input  logic        ext_busy_i,
   input  logic [31:0] ext_rdata_i,
   output logic [1:0]  ext_rwi_o,
   output logic [31:0] ext_addr_o,
   output logic [31:0] ext_wdata_o,
   output logic [1:0]  grant_o,
   output logic        error_o
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX      = CW'(TIMEOUT_CYCLES);
   localparam logic [31:0]   TIMEOUT_RESP = 32'hDEADBEEF;
   localparam logic [1:0]    RWI_IDLE     = 2'b00;
   localparam logic [1:0]    RWI_WRITE    = 2'b01;
   localparam logic [1:0]    RWI_READ     = 2'b10;
   localparam logic [1:0]    RWI_FETCH    = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t         state_reg;
   logic           prev_busy_reg;
   logic [CW-1:0]  cnt_reg;
   logic           winner_reg;        // 0 = fetch, 1 = data
   logic           last_served_reg;   // 0 = fetch, 1 = data
   logic [1:0]     rwi_reg;
   logic [1:0]     grant_reg;
   logic [1:0]     ack_reg;
   logic [31:0]    addr_reg;
   logic [31:0]    wdata_reg;
   logic           error_reg;

   logic           done;
   logic           timeout;
   logic           in_flight;
   logic           finish;
   logic           pick_data;
   logic [1:0]     req_vec;
   logic [1:0]     capture_en;
   logic [31:0]    capture_val;

   assign req_vec     = {data_req_i, fetch_req_i};
   assign done        = prev_busy_reg & ~ext_busy_i;
   assign in_flight   = (state_reg == S_ISSUE) || (state_reg == S_WAIT);
   assign timeout     = (state_reg == S_WAIT) && !done && (cnt_reg == CNT_MAX);
   assign finish      = in_flight && (done || timeout);
   assign capture_val = timeout ? TIMEOUT_RESP : ext_rdata_i;

   always_comb begin
      pick_data = 1'b0;
      case (req_vec)
         2'b10:   pick_data = 1'b1;
         2'b11:   pick_data = (FAIR_RR != 0) ? ~last_served_reg : 1'b1;
         default: pick_data = 1'b0;
      endcase
   end

   // A completed store leaves the data response alone; an aborted one reports the poison word.
   always_comb begin
      capture_en = 2'b00;
      if (finish) begin
         if (!winner_reg) begin
            capture_en[0] = 1'b1;
         end else if (timeout || (rwi_reg != RWI_WRITE)) begin
            capture_en[1] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_reg       <= S_IDLE;
         prev_busy_reg   <= 1'b0;
         cnt_reg         <= '0;
         winner_reg      <= 1'b0;
         last_served_reg <= 1'b1;
         rwi_reg         <= RWI_IDLE;
         grant_reg       <= 2'b00;
         ack_reg         <= 2'b00;
         addr_reg        <= '0;
         wdata_reg       <= '0;
         error_reg       <= 1'b0;
      end else begin
         prev_busy_reg <= ext_busy_i;
         ack_reg       <= 2'b00;
         error_reg     <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (|req_vec) begin
                  winner_reg <= pick_data;
                  grant_reg  <= pick_data ? 2'b10 : 2'b01;
                  cnt_reg    <= '0;
                  if (pick_data) begin
                     rwi_reg   <= data_we_i ? RWI_WRITE : RWI_READ;
                     addr_reg  <= data_addr_i;
                     wdata_reg <= data_we_i ? data_wdata_i : 32'd0;
                  end else begin
                     rwi_reg   <= RWI_FETCH;
                     addr_reg  <= fetch_addr_i;
                     wdata_reg <= 32'd0;
                  end
                  state_reg <= S_ISSUE;
               end
            end
            S_ISSUE, S_WAIT: begin
               cnt_reg <= (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CW'(1);
               if (finish) begin
                  rwi_reg   <= RWI_IDLE;
                  ack_reg   <= winner_reg ? 2'b10 : 2'b01;
                  error_reg <= timeout;
                  state_reg <= S_DONE;
               end else begin
                  state_reg <= S_WAIT;
               end
            end
            S_DONE: begin
               last_served_reg <= winner_reg;
               grant_reg       <= 2'b00;
               state_reg       <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      logic [31:0] resp_reg;
      always_ff @(posedge clk or negedge nrst) begin
         if (!nrst) begin
            resp_reg <= '0;
         end else if (capture_en[gi]) begin
            resp_reg <= capture_val;
         end
      end
   end

   assign fetch_ack_o  = ack_reg[0];
   assign data_ack_o   = ack_reg[1];
   assign fetch_data_o = g_resp[0].resp_reg;
   assign data_rdata_o = g_resp[1].resp_reg;
   assign ext_rwi_o    = rwi_reg;
   assign ext_addr_o   = addr_reg;
   assign ext_wdata_o  = wdata_reg;
   assign grant_o      = grant_reg;
   assign error_o      = error_reg;

endmodule

// File: tb/tb_t07_mem_arbiter.sv
// Bench for t07_mem_arbiter: a round-robin and a fixed-priority instance share the request
// inputs; each has its own busy/rdata memory responder; results checked against a rule model.
module tb_t07_mem_arbiter;

   localparam int T = 8;

   logic        clk;
   logic        nrst;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        data_req;
   logic        data_we;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;

   logic        fetch_ack_v  [2];
   logic [31:0] fetch_data_v [2];
   logic        data_ack_v   [2];
   logic [31:0] data_rdata_v [2];
   logic        busy_v       [2];
   logic [31:0] rdata_v      [2];
   logic [1:0]  rwi_v        [2];
   logic [31:0] addr_v       [2];
   logic [31:0] wdata_v      [2];
   logic [1:0]  grant_v      [2];
   logic        error_v      [2];

   // instance 0: round-robin, instance 1: fixed priority (data first)
   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      t07_mem_arbiter #(
         .TIMEOUT_CYCLES(T),
         .FAIR_RR((gi == 0) ? 1 : 0)
      ) u_dut (
         .clk          (clk),
         .nrst         (nrst),
         .fetch_req_i  (fetch_req),
         .fetch_addr_i (fetch_addr),
         .fetch_ack_o  (fetch_ack_v[gi]),
         .fetch_data_o (fetch_data_v[gi]),
         .data_req_i   (data_req),
         .data_we_i    (data_we),
         .data_addr_i  (data_addr),
         .data_wdata_i (data_wdata),
         .data_ack_o   (data_ack_v[gi]),
         .data_rdata_o (data_rdata_v[gi]),
         .ext_busy_i   (busy_v[gi]),
         .ext_rdata_i  (rdata_v[gi]),
         .ext_rwi_o    (rwi_v[gi]),
         .ext_addr_o   (addr_v[gi]),
         .ext_wdata_o  (wdata_v[gi]),
         .grant_o      (grant_v[gi]),
         .error_o      (error_v[gi])
      );
   end

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [31:0] exp_fd = 32'd0;
   logic [31:0] exp_dd = 32'd0;
   int          mem_lat = 1;          // busy-high cycles; negative = never completes
   logic [31:0] mem_rd = 32'd0;

   int          phase     [2];
   int          busy_cnt  [2];
   int          issue_cyc [2];
   logic [1:0]  seen_rwi  [2];
   logic [31:0] seen_addr [2];
   logic [31:0] seen_wdata[2];
   logic [1:0]  seen_grant[2];
   bit          hold_ok   [2];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Memory responder: raises busy when a command appears, drops it after mem_lat cycles.
   initial begin
      for (int i = 0; i < 2; i++) begin
         busy_v[i] = 1'b0;
         rdata_v[i] = 32'd0;
         phase[i] = 0;
         hold_ok[i] = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (!nrst) begin
               busy_v[i] = 1'b0;
               phase[i] = 0;
            end else if (phase[i] == 0) begin
               if (rwi_v[i] != 2'b00) begin
                  busy_v[i] = 1'b1;
                  busy_cnt[i] = 0;
                  phase[i] = 1;
                  issue_cyc[i] = cyc;
                  seen_rwi[i] = rwi_v[i];
                  seen_addr[i] = addr_v[i];
                  seen_wdata[i] = wdata_v[i];
                  seen_grant[i] = grant_v[i];
                  hold_ok[i] = 1'b1;
                  rdata_v[i] = $urandom;
               end
            end else if (phase[i] == 1) begin
               busy_cnt[i]++;
               if (rwi_v[i] == 2'b00) begin
                  busy_v[i] = 1'b0;
                  phase[i] = 0;
               end else begin
                  if (rwi_v[i] != seen_rwi[i] || addr_v[i] != seen_addr[i] ||
                      wdata_v[i] != seen_wdata[i] || grant_v[i] != seen_grant[i])
                     hold_ok[i] = 1'b0;
                  if (mem_lat >= 0 && busy_cnt[i] == mem_lat) begin
                     busy_v[i] = 1'b0;
                     rdata_v[i] = mem_rd;
                     phase[i] = 2;
                  end
               end
            end else if (rwi_v[i] == 2'b00) begin
               phase[i] = 0;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_rwi_grant"}, 32'({rwi_v[0], grant_v[0]}), 32'd0);
      chk({tag, "_addr"}, addr_v[0], 32'd0);
      chk({tag, "_wdata"}, wdata_v[0], 32'd0);
      chk({tag, "_ack_err"}, 32'({fetch_ack_v[0], data_ack_v[0], error_v[0]}), 32'd0);
      chk({tag, "_fetch_data"}, fetch_data_v[0], exp_fd);
      chk({tag, "_data_rdata"}, data_rdata_v[0], exp_dd);
   endtask

   task automatic drive(input bit is_fetch, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata);
      if (is_fetch) begin
         fetch_req = 1'b1;
         fetch_addr = addr;
      end else begin
         data_req = 1'b1;
         data_we = we;
         data_addr = addr;
         data_wdata = wdata;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      nrst = 1'b0;
      fetch_req = 1'b0;
      data_req = 1'b0;
      exp_fd = 32'd0;
      exp_dd = 32'd0;
      repeat (2) @(negedge clk);
      nrst = 1'b1;
   endtask

   // Waits for the ack of one single-requester transaction and checks it against the rules:
   // completion lat+1 cycles after issue, or a poisoned abort after T wait cycles.
   task automatic expect_txn(input string tag, input bit is_fetch, input bit we,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int lat, input logic [31:0] rd);
      bit          got;
      bit          exp_err;
      int          wait_cycles;
      logic [31:0] resp;
      logic [1:0]  exp_own;
      logic [1:0]  exp_rwi;
      mem_lat = lat;
      mem_rd = rd;
      got = 1'b0;
      for (int n = 0; n < 60 && !got; n++) begin
         @(negedge clk);
         got = fetch_ack_v[0] | data_ack_v[0];
      end
      chk({tag, "_ack_seen"}, 32'(got), 32'd1);
      if (got) begin
         exp_err = (lat < 0) || (lat > T);
         wait_cycles = exp_err ? T : lat;
         resp = exp_err ? 32'hDEADBEEF : rd;
         exp_own = is_fetch ? 2'b01 : 2'b10;
         exp_rwi = is_fetch ? 2'b11 : (we ? 2'b01 : 2'b10);
         if (is_fetch) exp_fd = resp;
         else if (!we || exp_err) exp_dd = resp;
         chk({tag, "_latency"}, 32'(cyc - issue_cyc[0]), 32'(wait_cycles + 1));
         chk({tag, "_ack_owner"}, 32'({data_ack_v[0], fetch_ack_v[0]}), 32'(exp_own));
         chk({tag, "_fetch_data"}, fetch_data_v[0], exp_fd);
         chk({tag, "_data_rdata"}, data_rdata_v[0], exp_dd);
         chk({tag, "_error"}, 32'(error_v[0]), 32'(exp_err));
         chk({tag, "_rwi"}, 32'(seen_rwi[0]), 32'(exp_rwi));
         chk({tag, "_addr"}, seen_addr[0], addr);
         chk({tag, "_wdata"}, seen_wdata[0], (!is_fetch && we) ? wdata : 32'd0);
         chk({tag, "_grant_issue"}, 32'(seen_grant[0]), 32'(exp_own));
         chk({tag, "_grant_done"}, 32'(grant_v[0]), 32'(exp_own));
         chk({tag, "_rwi_done"}, 32'(rwi_v[0]), 32'd0);
         chk({tag, "_held"}, 32'(hold_ok[0]), 32'd1);
      end
   endtask

   task automatic release_and_check(input string tag);
      fetch_req = 1'b0;
      data_req = 1'b0;
      @(negedge clk);
      chk({tag, "_one_pulse"}, 32'({data_ack_v[0], fetch_ack_v[0]}), 32'd0);
   endtask

   initial begin
      int          kind;
      int          rl;
      int          t1;
      int          t2;
      int          na;
      int          nb;
      int          acks;
      bit          seen;
      logic [31:0] ra;
      logic [31:0] rw;
      logic [31:0] rr;

      nrst = 1'b0;
      fetch_req = 1'b0;
      fetch_addr = 32'd0;
      data_req = 1'b0;
      data_we = 1'b0;
      data_addr = 32'd0;
      data_wdata = 32'd0;

      // reset state
      repeat (3) @(negedge clk);
      chk_idle("reset");
      nrst = 1'b1;

      // fetch alone
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h0000_0100, 32'd0);
      expect_txn("fetch", 1'b1, 1'b0, 32'h0000_0100, 32'd0, 3, 32'h0000_0013);
      release_and_check("fetch");

      // store
      @(negedge clk);
      drive(1'b0, 1'b1, 32'h0000_2000, 32'hCAFE_F00D);
      expect_txn("store", 1'b0, 1'b1, 32'h0000_2000, 32'hCAFE_F00D, 2, 32'h1234_5678);
      release_and_check("store");

      // load
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0000_3004, 32'd0);
      expect_txn("load", 1'b0, 1'b0, 32'h0000_3004, 32'd0, 4, 32'hA5A5_0F0F);
      release_and_check("load");

      // randomized single-requester traffic, latencies spanning the timeout
      for (int r = 0; r < 10; r++) begin
         kind = int'($urandom_range(0, 2));
         ra = $urandom;
         rw = $urandom;
         rr = $urandom;
         rl = int'($urandom_range(1, 10));
         @(negedge clk);
         drive(kind == 0, kind == 2, ra, rw);
         expect_txn($sformatf("rnd%0d", r), kind == 0, kind == 2, ra, rw, rl, rr);
         release_and_check($sformatf("rnd%0d", r));
      end

      // timeout: never completes, completes on the timeout cycle, completes one cycle late
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0000_0040, 32'd0);
      expect_txn("to_never", 1'b0, 1'b0, 32'h0000_0040, 32'd0, -1, 32'h1111_1111);
      release_and_check("to_never");
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0000_0044, 32'd0);
      expect_txn("to_edge", 1'b0, 1'b0, 32'h0000_0044, 32'd0, T, 32'h2222_2222);
      release_and_check("to_edge");
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h0000_0048, 32'd0);
      expect_txn("to_late", 1'b1, 1'b0, 32'h0000_0048, 32'd0, T + 1, 32'h3333_3333);
      release_and_check("to_late");

      // back-to-back fetches with the request held across the ack
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h0000_0300, 32'd0);
      expect_txn("b2b_a", 1'b1, 1'b0, 32'h0000_0300, 32'd0, 1, 32'h0000_0093);
      t1 = cyc;
      fetch_addr = 32'h0000_0304;
      @(negedge clk);
      chk("b2b_one_pulse", 32'({data_ack_v[0], fetch_ack_v[0]}), 32'd0);
      expect_txn("b2b_b", 1'b1, 1'b0, 32'h0000_0304, 32'd0, 1, 32'h0000_0113);
      t2 = cyc;
      chk("b2b_gap_ge4", 32'((t2 - t1) >= 4), 32'd1);
      release_and_check("b2b");

      // contention from reset: round-robin alternates starting with fetch, fixed picks data
      do_reset();
      @(negedge clk);
      mem_lat = 1;
      mem_rd = 32'h0BAD_F00D;
      fetch_req = 1'b1;
      fetch_addr = 32'h0000_0400;
      data_req = 1'b1;
      data_we = 1'b0;
      data_addr = 32'h0000_0800;
      na = 0;
      nb = 0;
      for (int n = 0; n < 200 && (na < 4 || nb < 4); n++) begin
         @(negedge clk);
         if (na < 4 && (fetch_ack_v[0] || data_ack_v[0])) begin
            chk($sformatf("rr_ack%0d", na), 32'({data_ack_v[0], fetch_ack_v[0]}),
                (na % 2 == 0) ? 32'd1 : 32'd2);
            na++;
         end
         if (nb < 4 && (fetch_ack_v[1] || data_ack_v[1])) begin
            chk($sformatf("fixed_ack%0d", nb), 32'({data_ack_v[1], fetch_ack_v[1]}), 32'd2);
            nb++;
         end
      end
      chk("contention_acks", 32'(na + nb), 32'd8);
      fetch_req = 1'b0;
      data_req = 1'b0;
      repeat (20) @(negedge clk);
      do_reset();

      // reset in the middle of a load
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0000_0500, 32'd0);
      mem_lat = -1;
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
         @(negedge clk);
         seen = (rwi_v[0] != 2'b00);
      end
      chk("midrst_issue", 32'(seen), 32'd1);
      repeat (2) @(negedge clk);
      #2 nrst = 1'b0;
      exp_fd = 32'd0;
      exp_dd = 32'd0;
      #1 chk_idle("midrst");
      data_req = 1'b0;
      acks = 0;
      repeat (3) begin
         @(negedge clk);
         if (fetch_ack_v[0] || data_ack_v[0]) acks++;
      end
      chk("midrst_no_ack", 32'(acks), 32'd0);
      nrst = 1'b1;
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h0000_0600, 32'd0);
      expect_txn("post_rst", 1'b1, 1'b0, 32'h0000_0600, 32'd0, 2, 32'h0000_0517);
      release_and_check("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/t07_mem_arbiter.md
Name: t07_mem_arbiter

Overview:
- Arbitrates one external memory/MMIO bus between two requesters: the instruction-fetch port and the load/store data port.
- Runs one transaction at a time over the rwi/busy protocol. Transaction end is the falling edge of ext_busy_i.
- Returns read data and a one-cycle ack to the winning requester, with round-robin or fixed priority and a completion timeout.
- Sits between the core's fetch/load-store sequencing and the external memory interface.

Parameters:
- TIMEOUT_CYCLES, 255: cycles spent in ISSUE+WAIT without completion before the transaction is aborted.
- FAIR_RR, 1: 1 = round-robin on contention; 0 = fixed priority, data over fetch.

Ports:
- clk  in  1  clock, all logic on rising edge
- nrst  in  1  asynchronous active-low reset
- fetch_req_i  in  1  fetch request, held until fetch_ack_o
- fetch_addr_i  in  32  fetch address
- fetch_ack_o  out  1  one-cycle completion pulse to fetch
- fetch_data_o  out  32  fetched instruction, valid while fetch_ack_o=1
- data_req_i  in  1  load/store request, held until data_ack_o
- data_we_i  in  1  1 = store, 0 = load
- data_addr_i  in  32  load/store address
- data_wdata_i  in  32  store data
- data_ack_o  out  1  one-cycle completion pulse to data port
- data_rdata_o  out  32  load data, valid while data_ack_o=1
- ext_busy_i  in  1  memory busy; high→low transition marks completion
- ext_rdata_i  in  32  memory read data, sampled on completion
- ext_rwi_o  out  2  00 idle, 01 write, 10 read, 11 fetch
- ext_addr_o  out  32  transaction address
- ext_wdata_o  out  32  write data
- grant_o  out  2  one-hot owner: bit0 fetch, bit1 data; 00 when idle
- error_o  out  1  one-cycle pulse with ack when the transaction timed out

Behaviour:
- Reset values (async on nrst low): state IDLE; all outputs 0; prev_busy 0; timeout counter 0; last_served = data, so the first tie goes to fetch.
- Edge detect: prev_busy <= ext_busy_i every cycle. done = prev_busy & ~ext_busy_i.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - ext_rwi_o=00, grant_o=00.
  - If any req, select a winner:
    - Only one requester → it wins.
    - Both with FAIR_RR=1 → the one not in last_served wins.
    - Both with FAIR_RR=0 → data wins.
  - Latch the winner's addr, wdata and kind into registers. Set grant_o; counter=0; go to ISSUE. No req → stay in IDLE.
- ISSUE (exactly 1 cycle):
  - ext_rwi_o = 11 for fetch, 01 for store, 10 for load. ext_addr_o/ext_wdata_o come from the latched registers (wdata=0 for reads).
  - Go to WAIT; counter+1.
- WAIT:
  - Hold ext_rwi_o, ext_addr_o, ext_wdata_o and grant_o; counter+1 each cycle.
  - On done: capture ext_rdata_i into the response register (fetch or load; a store leaves it unchanged), go to DONE.
  - Else if counter == TIMEOUT_CYCLES: response = 32'hDEADBEEF, set the error flag, go to DONE.
  - done takes precedence over timeout in the same cycle.
  - done is honoured in ISSUE as well: in that case skip WAIT and go straight to DONE.
- DONE (1 cycle):
  - ext_rwi_o=00. The winner's ack=1 with its data output valid; error_o=1 if timed out.
  - last_served <= winner; grant_o cleared on exit; return to IDLE.
- Handshake rules:
  - A requester keeps req and its operands stable from assertion until the edge where its ack is high.
  - At that edge it may drop req or keep it high with new operands; keeping it high is a new request, re-arbitrated in the next IDLE.
  - Minimum spacing between transactions is 4 cycles (IDLE, ISSUE, ≥0 WAIT, DONE).
- fetch_data_o/data_rdata_o hold their last value between acks. Acks are never asserted together.
- Operands changing after the IDLE latch have no effect on the in-flight transaction.
- Reset mid-transaction returns to IDLE immediately: rwi=00, no ack issued.
- Counter width is clog2(TIMEOUT_CYCLES+1) bits and saturates; no wrap.

Test Plan:
- Fetch alone: fetch_req_i=1 with addr 0x0000_0100; busy high for 3 cycles then low, ext_rdata_i=0x0000_0013 → ext_rwi_o=11 from ISSUE until done, then fetch_ack_o pulses once with fetch_data_o=0x13; grant_o=01 through the transaction.
- Store: data_req_i=1, we=1, addr 0x2000, wdata 0xCAFEF00D → ext_rwi_o=01, ext_addr_o=0x2000, ext_wdata_o=0xCAFEF00D; data_ack_o pulses; data_rdata_o unchanged.
- Contention with FAIR_RR=1: both requesters held high continuously → grants alternate fetch, data, fetch, data; with FAIR_RR=0 → data is granted every time.
- Timeout with TIMEOUT_CYCLES=8: busy held high → ack plus error_o on the same cycle and data_rdata_o=0xDEADBEEF; done arriving on the timeout cycle → normal data and error_o=0.
- Reset mid-WAIT: nrst low during a load → all outputs 0 asynchronously, no ack; after release, a new fetch completes normally.
- Back-to-back: fetch req held high across its ack with a new addr → second transaction latches the new addr; gap between ack pulses is ≥4 cycles.
